// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake between the multicycle controller
// and the memory port: request, write qualifier, address select and ready.
interface multicycle_controller_if;
    logic memReq;
    logic memWrite;
    logic adrSrc;
    logic memReady;

    modport master (
        output memReq,
        output memWrite,
        output adrSrc,
        input  memReady
    );

    modport slave (
        input  memReq,
        input  memWrite,
        input  adrSrc,
        output memReady
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core with memory wait-state timeout.
// Optional: define MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN to fault/halt on unknown opcodes.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [6:0]               i_operand,
    input  logic [2:0]               i_funct3,
    input  logic                     i_funct7bit5,
    input  logic                     i_zero,
    multicycle_controller_if.master  mem,
    output logic                     o_irWrite,
    output logic                     o_pcWrite,
    output logic                     o_regWrite,
    output logic [1:0]               o_aluSrcA,
    output logic [1:0]               o_aluSrcB,
    output logic [1:0]               o_resultSrc,
    output logic [3:0]               o_aluLogicOperation,
    output logic                     o_fault
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          mem_state;
    logic          timeout;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign o_fault = fault_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d             = state_q;
        cnt_d               = '0;
        fault_d             = fault_q;
        timeout             = 1'b0;
        mem.memReq          = 1'b0;
        mem.memWrite        = 1'b0;
        mem.adrSrc          = 1'b0;
        o_irWrite           = 1'b0;
        o_pcWrite           = 1'b0;
        o_regWrite          = 1'b0;
        o_aluSrcA           = 2'b00;
        o_aluSrcB           = 2'b00;
        o_resultSrc         = 2'b00;
        o_aluLogicOperation = 4'b0000;

        mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);

        // Counter only runs while a memory state waits; any ready or exit clears it.
        if (mem_state && !mem.memReady && (TIMEOUT_CYCLES != 0)) begin
            if (cnt_inc == TMO) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.memReq  = 1'b1;
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                o_irWrite   = mem.memReady;
                o_pcWrite   = mem.memReady;
                if (mem.memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
                case (i_operand)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
                        fault_d = 1'b1;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
                state_d   = (i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem.memReq = 1'b1;
                mem.adrSrc = 1'b1;
                if (mem.memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                o_resultSrc = 2'b01;
                o_regWrite  = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem.memReq   = 1'b1;
                mem.memWrite = 1'b1;
                mem.adrSrc   = 1'b1;
                if (mem.memReady) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = {i_funct7bit5, i_funct3};
                state_d             = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_aluSrcA           = 2'b10;
                o_aluSrcB           = 2'b01;
                // Bit 30 is an immediate bit for every I-op except srai.
                o_aluLogicOperation = {i_funct7bit5 & (i_funct3 == 3'b101), i_funct3};
                state_d             = S_ALUWB;
            end
            S_ALUWB: begin
                o_regWrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b10;
                o_pcWrite = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = 4'b1000;
                o_pcWrite           = i_zero;
                state_d             = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (timeout) begin
            state_d = S_HALT;
            fault_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (TIMEOUT_CYCLES = 4).
module tb_multicycle_controller;

    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic [6:0] i_operand = 7'd0;
    logic [2:0] i_funct3 = 3'd0;
    logic       i_funct7bit5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       o_irWrite, o_pcWrite, o_regWrite, o_fault;
    logic [1:0] o_aluSrcA, o_aluSrcB, o_resultSrc;
    logic [3:0] o_aluLogicOperation;

    int vecs  = 0;
    int fails = 0;

    multicycle_controller_if mif ();

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk               (i_clk),
        .i_arst_n            (i_arst_n),
        .i_operand           (i_operand),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .i_zero              (i_zero),
        .mem                 (mif.master),
        .o_irWrite           (o_irWrite),
        .o_pcWrite           (o_pcWrite),
        .o_regWrite          (o_regWrite),
        .o_aluSrcA           (o_aluSrcA),
        .o_aluSrcB           (o_aluSrcB),
        .o_resultSrc         (o_resultSrc),
        .o_aluLogicOperation (o_aluLogicOperation),
        .o_fault             (o_fault)
    );

    always #5 i_clk = ~i_clk;

    // {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, A, B, res, op, fault}
    localparam logic [16:0] P_ZERO    = 17'h0;
    localparam logic [16:0] P_FETCH_R = {6'b100110, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0};
    localparam logic [16:0] P_FETCH_W = {6'b100000, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0};
    localparam logic [16:0] P_DECODE  = {6'b000000, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_EXR_ADD = {6'b000000, 2'b10, 2'b00, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_EXR_SUB = {6'b000000, 2'b10, 2'b00, 2'b00, 4'h8, 1'b0};
    localparam logic [16:0] P_ALUWB   = {6'b000001, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_MEMADR  = {6'b000000, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_MEMRD   = {6'b101000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_MEMWB   = {6'b000001, 2'b00, 2'b00, 2'b01, 4'h0, 1'b0};
    localparam logic [16:0] P_MEMWR   = {6'b111000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_EXI_SRA = {6'b000000, 2'b10, 2'b01, 2'b00, 4'hD, 1'b0};
    localparam logic [16:0] P_EXI_ADD = {6'b000000, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_JAL     = {6'b000010, 2'b01, 2'b10, 2'b00, 4'h0, 1'b0};
    localparam logic [16:0] P_BEQ_T   = {6'b000010, 2'b10, 2'b00, 2'b00, 4'h8, 1'b0};
    localparam logic [16:0] P_BEQ_N   = {6'b000000, 2'b10, 2'b00, 2'b00, 4'h8, 1'b0};
    localparam logic [16:0] P_HALT    = 17'h00001;

    function automatic logic [16:0] pack();
        return {mif.memReq, mif.memWrite, mif.adrSrc, o_irWrite, o_pcWrite, o_regWrite,
                o_aluSrcA, o_aluSrcB, o_resultSrc, o_aluLogicOperation, o_fault};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_cycle();
        i_arst_n = 1'b0;
        tick();
        i_arst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        mif.memReady = 1'b0;
        #3;
        vecs++;
        if (pack() !== P_ZERO) begin
            fails++;
            $display("FAIL reset_held_t0: got %h, expected %h", pack(), P_ZERO);
        end
        tick();
        tick();
        vecs++;
        if (pack() !== P_ZERO) begin
            fails++;
            $display("FAIL reset_held_clocked: got %h, expected %h", pack(), P_ZERO);
        end
        i_arst_n = 1'b1;
        #1;
        vecs++;
        if (pack() !== P_ZERO) begin
            fails++;
            $display("FAIL reset_state_after_release: got %h, expected %h", pack(), P_ZERO);
        end
        tick();
        #1;
        vecs++;
        if (pack() !== P_FETCH_W) begin
            fails++;
            $display("FAIL first_fetch: got %h, expected %h", pack(), P_FETCH_W);
        end
    endtask

    task automatic test_r_type(input logic b5, input logic [16:0] exec_pat, input string nm);
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b0110011; i_funct3 = 3'b000; i_funct7bit5 = b5;
        e = {P_FETCH_R, P_DECODE, exec_pat, P_ALUWB, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b0000011; i_funct3 = 3'b010; i_funct7bit5 = 1'b0;
        e = {P_FETCH_R, P_DECODE, P_MEMADR, P_MEMRD, P_MEMRD, P_MEMRD, P_MEMWB, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL lw_wait2 cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_sw();
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b0100011; i_funct3 = 3'b010; i_funct7bit5 = 1'b0;
        e = {P_FETCH_R, P_DECODE, P_MEMADR, P_MEMWR, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL sw cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_beq(input logic z, input logic [16:0] beq_pat);
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b1100011; i_funct3 = 3'b000; i_funct7bit5 = 1'b0; i_zero = z;
        e = {P_FETCH_R, P_DECODE, beq_pat, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL beq_z%0d cycle %0d: got %h, expected %h", z, c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
        i_zero = 1'b0;
    endtask

    task automatic test_i_type(input logic [2:0] f3, input logic [16:0] exec_pat, input string nm);
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b0010011; i_funct3 = f3; i_funct7bit5 = 1'b1;
        e = {P_FETCH_R, P_DECODE, exec_pat, P_ALUWB, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_jal();
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b1101111; i_funct3 = 3'b000; i_funct7bit5 = 1'b0;
        e = {P_FETCH_R, P_DECODE, P_JAL, P_ALUWB, P_FETCH_W};
        r = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL jal cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e[$];
        logic        r[$];
        i_operand = 7'b1111111; i_funct3 = 3'b000; i_funct7bit5 = 1'b0;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        e = {P_FETCH_R, P_DECODE, P_HALT, P_HALT};
`else
        e = {P_FETCH_R, P_DECODE, P_FETCH_W, P_FETCH_R};
`endif
        r = {1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL illegal_op cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
    endtask

    task automatic test_reset_mid_write();
        logic [16:0] e[$];
        logic        r[$];
        mif.memReady = 1'b0;
        reset_cycle();
        i_operand = 7'b0100011; i_funct3 = 3'b010;
        e = {P_FETCH_R, P_DECODE, P_MEMADR, P_MEMWR};
        r = {1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < e.size(); c++) begin
            mif.memReady = r[c];
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL mid_write_setup cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c < e.size() - 1) tick();
        end
        #1;
        i_arst_n = 1'b0;
        #1;
        vecs++;
        if (pack() !== P_ZERO) begin
            fails++;
            $display("FAIL reset_mid_write: got %h, expected %h", pack(), P_ZERO);
        end
        tick();
        i_arst_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic [16:0] e[$];
        mif.memReady = 1'b0;
        tick();
        e = {P_FETCH_W, P_FETCH_W, P_FETCH_W, P_FETCH_W, P_HALT, P_HALT, P_HALT};
        for (int c = 0; c < e.size(); c++) begin
            #1;
            vecs++;
            if (pack() !== e[c]) begin
                fails++;
                $display("FAIL timeout cycle %0d: got %h, expected %h", c, pack(), e[c]);
            end
            if (c == 5) mif.memReady = 1'b1;
            if (c < e.size() - 1) tick();
        end
        i_arst_n = 1'b0;
        #1;
        vecs++;
        if (pack() !== P_ZERO) begin
            fails++;
            $display("FAIL timeout_reset_clear: got %h, expected %h", pack(), P_ZERO);
        end
        tick();
        i_arst_n = 1'b1;
    endtask

    initial begin
        mif.memReady = 1'b0;
        test_reset();
        test_r_type(1'b0, P_EXR_ADD, "r_add");
        test_r_type(1'b1, P_EXR_SUB, "r_sub");
        test_lw_wait();
        test_sw();
        test_beq(1'b1, P_BEQ_T);
        test_beq(1'b0, P_BEQ_N);
        test_i_type(3'b101, P_EXI_SRA, "srai");
        test_i_type(3'b000, P_EXI_ADD, "addi_b5");
        test_jal();
        test_illegal();
        test_reset_mid_write();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RISC-V core: sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath mux selects, ALU operation and write strobes. It adds a ready/request handshake to the shared instruction/data memory with a bounded wait-state timeout. It sits beside the `pa_riscv` decode package and replaces the single-cycle combinational controller in the multicycle datapath.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum wait cycles in one memory state before a fault. 0 disables the timeout.
- `i_clk`  in  1  core clock.
- `i_arst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_operand`  in  7  opcode field of the instruction register.
- `i_funct3`  in  3  funct3 field.
- `i_funct7bit5`  in  1  bit 30 of the instruction.
- `i_zero`  in  1  ALU zero flag.
- `i_memReady`  in  1  memory completes the current access this cycle.
- `o_memReq`  out  1  memory access requested.
- `o_memWrite`  out  1  requested access is a write.
- `o_adrSrc`  out  1  memory address select: 0 = PC, 1 = result bus.
- `o_irWrite`  out  1  load instruction register and OldPC.
- `o_pcWrite`  out  1  load PC from the result bus.
- `o_regWrite`  out  1  register file write.
- `o_aluSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rd1.
- `o_aluSrcB`  out  2  ALU B select: 00 = rd2, 01 = immediate, 10 = constant 4.
- `o_resultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `o_aluLogicOperation`  out  4  ALU operation `{funct7bit5, funct3}`; add = 0000, sub = 1000.
- `o_fault`  out  1  sticky: memory timeout (or illegal opcode, see Configuration).

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, HALT.
- All outputs are Moore decodes of state, except the FETCH strobes and the BEQ `o_pcWrite`.
- Any output not listed for a state is 0.
- **RESET**: no outputs asserted; goes to FETCH unconditionally.
- **FETCH**: `memReq`=1, `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, op 0000, `resultSrc`=10.
  - `irWrite` and `pcWrite` equal `i_memReady`.
  - Goes to DECODE on ready, otherwise stays.
- **DECODE**: `aluSrcA`=01, `aluSrcB`=01, op 0000 (branch target).
  - lw (0000011) or sw (0100011) → MEMADR.
  - R (0110011) → EXECUTER.
  - I (0010011) → EXECUTEI.
  - jal (1101111) → JAL.
  - beq (1100011) → BEQ.
  - Other opcodes → FETCH (treated as a NOP).
- **MEMADR**: `aluSrcA`=10, `aluSrcB`=01, op 0000. lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD**: `memReq`=1, `adrSrc`=1, `resultSrc`=00. Goes to MEMWB on ready.
- **MEMWB**: `resultSrc`=01, `regWrite`=1; → FETCH.
- **MEMWRITE**: `memReq`=1, `memWrite`=1, `adrSrc`=1, `resultSrc`=00. Goes to FETCH on ready.
- **EXECUTER**: `aluSrcA`=10, `aluSrcB`=00, op = `{funct7bit5, funct3}`; → ALUWB.
- **EXECUTEI**: `aluSrcA`=10, `aluSrcB`=01.
  - op = `{funct7bit5 & (funct3==101), funct3}`, so only srai uses bit 30.
  - → ALUWB.
- **ALUWB**: `resultSrc`=00, `regWrite`=1; → FETCH.
- **JAL**: `aluSrcA`=01, `aluSrcB`=10, op 0000, `resultSrc`=00, `pcWrite`=1; → ALUWB (writes PC+4 to rd).
- **BEQ**: `aluSrcA`=10, `aluSrcB`=00, op 1000, `resultSrc`=00, `pcWrite`=`i_zero`; → FETCH.
- **Wait counter**:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to any memory state and on ready.
  - Increments each cycle a memory state waits with `i_memReady`=0.
  - When it reaches `TIMEOUT_CYCLES` while still waiting: `o_fault` is set and the next state is HALT.
  - A ready in the same cycle as the limit completes normally; ready wins.
- **HALT**: all outputs 0 except `o_fault`=1. Leaves only on reset.

## Timing
- Reset assert (async): state = RESET, counter = 0, `o_fault` = 0. Every output is 0 while reset is held.
- First `o_memReq` appears one cycle after reset deassertion.
- Cycles per instruction with zero-wait memory: beq 3; R, I, jal and sw 4; lw 5. Each wait cycle adds 1.
- `o_memReq` stays high every waiting cycle. The address select and `memWrite` stay stable until ready.

## Configuration
- `MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN`:
  - Defined: an unrecognised opcode in DECODE sets `o_fault` and goes to HALT.
  - Undefined: an unrecognised opcode returns to FETCH with no side effects, and `o_fault` reflects timeouts only.

## Test plan
- Zero-wait R add (funct3 000, bit5 0): 4 cycles; EXECUTER op 0000; ALUWB `regWrite`=1; next FETCH on cycle 5.
- lw with 2 wait cycles in MEMREAD: `memReq`/`adrSrc`=1 held 3 cycles; MEMWB `resultSrc`=01, `regWrite`=1; total 7 cycles.
- beq with `i_zero`=1 → `pcWrite`=1 in BEQ. Same with `i_zero`=0 → `pcWrite`=0. Both take 3 cycles.
- I-type srai (funct3 101, bit5 1) → op 1101. addi with bit5 1 (funct3 000) → op 0000.
- `TIMEOUT_CYCLES`=4, `i_memReady` held 0 in FETCH → `o_fault` rises after 4 wait cycles, state HALT, `memReq`=0. Async reset clears it.
- Opcode 1111111: with the macro → HALT and `o_fault`=1; without → FETCH after DECODE. Reset asserted mid-MEMWRITE → outputs 0 immediately.
